ram_dp_be: RTL and testbench



---
 rtl/ram_dp_be.sv | 144 ++++++++++++++
 tb/tb_ram_dp_be.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/ram_dp_be.sv
// Simple dual-port synchronous RAM with byte enables, 1- or 2-cycle read latency,
// selectable read-during-write behaviour and a post-reset clear sweep.
module ram_dp_be #(
    parameter int DATA_W     = 24,
    parameter int ADDR_W     = 16,
    parameter int RD_LAT     = 1,
    parameter int RDW_MODE   = 0,
    parameter int CLR_ON_RST = 1
) (
    input  logic                  CK,
    input  logic                  RST,
    input  logic                  WE,
    input  logic [ADDR_W-1:0]     WA,
    input  logic [DATA_W/8-1:0]   WBE,
    input  logic [DATA_W-1:0]     D,
    input  logic                  RE,
    input  logic [ADDR_W-1:0]     RA,
    input  logic                  OE,
    output logic [DATA_W-1:0]     Q,
    output logic                  QV,
    output logic                  BUSY
);

    localparam int NB = DATA_W / 8;
    localparam logic [ADDR_W-1:0] LAST_ADDR = {ADDR_W{1'b1}};
    localparam logic [ADDR_W-1:0] ADDR_ONE  = {{(ADDR_W-1){1'b0}}, 1'b1};

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_CLEAR = 1'b1
    } state_t;

    logic [DATA_W-1:0] mem [0:(1<<ADDR_W)-1];

    state_t            state_r;
    logic [ADDR_W-1:0] clr_cnt_r;
    logic              s1_v_r;
    logic [DATA_W-1:0] s1_data_r;
    logic [DATA_W-1:0] q_r;
    logic              qv_r;

    logic              wr_acc_s;
    logic              rd_acc_s;
    logic              collide_s;
    logic [DATA_W-1:0] rd_word_s;

    // Replace the bytes of old_word selected by be with the matching bytes of new_word.
    function automatic logic [DATA_W-1:0] byte_merge(
        input logic [DATA_W-1:0] old_word,
        input logic [DATA_W-1:0] new_word,
        input logic [NB-1:0]     be
    );
        logic [DATA_W-1:0] res;
        res = old_word;
        for (int i = 0; i < NB; i++) begin
            if (be[i]) begin
                res[8*i +: 8] = new_word[8*i +: 8];
            end else begin
                res[8*i +: 8] = old_word[8*i +: 8];
            end
        end
        return res;
    endfunction

    // Request qualification and read-word selection, including same-address bypass.
    always_comb begin
        wr_acc_s  = 1'b0;
        rd_acc_s  = 1'b0;
        collide_s = 1'b0;
        rd_word_s = mem[RA];
        if (!RST && state_r == ST_IDLE) begin
            wr_acc_s = WE;
            rd_acc_s = RE;
        end else begin
            wr_acc_s = 1'b0;
            rd_acc_s = 1'b0;
        end
        collide_s = wr_acc_s && (WA == RA);
        if (RDW_MODE == 1 && collide_s) begin
            rd_word_s = byte_merge(mem[RA], D, WBE);
        end else begin
            rd_word_s = mem[RA];
        end
    end

    // Array update: the clear sweep owns the write port while it runs.
    always_ff @(posedge CK) begin
        if (state_r == ST_CLEAR) begin
            mem[clr_cnt_r] <= {DATA_W{1'b0}};
        end else if (wr_acc_s) begin
            mem[WA] <= byte_merge(mem[WA], D, WBE);
        end
    end

    // Control state, clear counter and read pipeline.
    always_ff @(posedge CK) begin
        if (RST) begin
            state_r   <= (CLR_ON_RST != 0) ? ST_CLEAR : ST_IDLE;
            clr_cnt_r <= {ADDR_W{1'b0}};
            s1_v_r    <= 1'b0;
            s1_data_r <= {DATA_W{1'b0}};
            q_r       <= {DATA_W{1'b0}};
            qv_r      <= 1'b0;
        end else begin
            case (state_r)
                ST_CLEAR: begin
                    clr_cnt_r <= clr_cnt_r + ADDR_ONE;
                    if (clr_cnt_r == LAST_ADDR) begin
                        state_r <= ST_IDLE;
                    end
                end
                ST_IDLE: begin
                    state_r <= ST_IDLE;
                end
                default: begin
                    state_r <= ST_IDLE;
                end
            endcase

            // Data is captured at the accepting edge, so later writes cannot alter it.
            s1_v_r <= rd_acc_s;
            if (rd_acc_s) begin
                s1_data_r <= rd_word_s;
            end

            if (RD_LAT == 2) begin
                qv_r <= s1_v_r;
                if (s1_v_r) begin
                    q_r <= s1_data_r;
                end
            end else begin
                qv_r <= rd_acc_s;
                if (rd_acc_s) begin
                    q_r <= rd_word_s;
                end
            end
        end
    end

    assign QV   = qv_r;
    assign BUSY = (state_r == ST_CLEAR);
    assign Q    = OE ? q_r : {DATA_W{1'bz}};

endmodule

// File: tb/tb_ram_dp_be.sv
// Directed bench for ram_dp_be: three instances (latency 1 old-data, latency 1
// new-data, latency 2 old-data) share one stimulus stream.
module tb_ram_dp_be;

    logic        ck;
    logic        rst;
    logic        we;
    logic [3:0]  wa;
    logic [2:0]  wbe;
    logic [23:0] d;
    logic        re;
    logic [3:0]  ra;
    logic        oe;

    wire [23:0]  q_a, q_b, q_c;
    wire         qv_a, qv_b, qv_c;
    wire         busy_a, busy_b, busy_c;

    int ntests = 0;
    int nfail  = 0;
    int n;

    ram_dp_be #(.DATA_W(24), .ADDR_W(4), .RD_LAT(1), .RDW_MODE(0), .CLR_ON_RST(1)) u_a (
        .CK(ck), .RST(rst), .WE(we), .WA(wa), .WBE(wbe), .D(d),
        .RE(re), .RA(ra), .OE(oe), .Q(q_a), .QV(qv_a), .BUSY(busy_a));

    ram_dp_be #(.DATA_W(24), .ADDR_W(4), .RD_LAT(1), .RDW_MODE(1), .CLR_ON_RST(1)) u_b (
        .CK(ck), .RST(rst), .WE(we), .WA(wa), .WBE(wbe), .D(d),
        .RE(re), .RA(ra), .OE(oe), .Q(q_b), .QV(qv_b), .BUSY(busy_b));

    ram_dp_be #(.DATA_W(24), .ADDR_W(4), .RD_LAT(2), .RDW_MODE(0), .CLR_ON_RST(1)) u_c (
        .CK(ck), .RST(rst), .WE(we), .WA(wa), .WBE(wbe), .D(d),
        .RE(re), .RA(ra), .OE(oe), .Q(q_c), .QV(qv_c), .BUSY(busy_c));

    initial ck = 1'b0;
    always #5 ck = ~ck;

    initial begin
        #200000;
        $display("FAIL watchdog: observed no finish, expected finish before 200000");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [23:0] obs, input logic [23:0] exp);
        ntests++;
        assert (obs === exp) else begin
            nfail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(negedge ck);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step();
        rst = 1'b0;
    endtask

    task automatic count_busy(output int cnt);
        cnt = 0;
        while (busy_a === 1'b1 && cnt < 100) begin
            cnt++;
            step();
        end
    endtask

    task automatic wr(input logic [3:0] a, input logic [23:0] data, input logic [2:0] be);
        we  = 1'b1;
        wa  = a;
        d   = data;
        wbe = be;
        step();
        we  = 1'b0;
    endtask

    task automatic rd(input string tag, input logic [3:0] a, input logic [23:0] e_a,
                      input logic [23:0] e_b, input logic [23:0] e_c);
        re = 1'b1;
        ra = a;
        step();
        re = 1'b0;
        chk({tag, "_qv_a"}, {23'd0, qv_a}, 24'd1);
        chk({tag, "_q_a"}, q_a, e_a);
        chk({tag, "_q_b"}, q_b, e_b);
        chk({tag, "_qv_c_early"}, {23'd0, qv_c}, 24'd0);
        step();
        chk({tag, "_qv_c"}, {23'd0, qv_c}, 24'd1);
        chk({tag, "_q_c"}, q_c, e_c);
        chk({tag, "_qv_a_strobe"}, {23'd0, qv_a}, 24'd0);
        chk({tag, "_q_a_hold"}, q_a, e_a);
    endtask

    initial begin
        rst = 1'b1; we = 1'b0; wa = 4'd0; wbe = 3'd0; d = 24'd0;
        re = 1'b0; ra = 4'd0; oe = 1'b1;

        // Reset state
        step();
        chk("rst_q_a", q_a, 24'h000000);
        chk("rst_qv_a", {23'd0, qv_a}, 24'd0);
        chk("rst_qv_c", {23'd0, qv_c}, 24'd0);
        chk("rst_busy", {23'd0, busy_a}, 24'd1);
        rst = 1'b0;
        count_busy(n);
        chk("busy_len_first", 24'(n), 24'd16);
        chk("busy_c_done", {23'd0, busy_c}, 24'd0);

        // Preload, then reset clears the whole array
        for (int i = 0; i < 16; i++) wr(4'(i), 24'hA5A5A5, 3'b111);
        rd("preload", 4'd7, 24'hA5A5A5, 24'hA5A5A5, 24'hA5A5A5);
        do_reset();
        count_busy(n);
        chk("busy_len_clear", 24'(n), 24'd16);
        for (int i = 0; i < 16; i++) begin
            re = 1'b1;
            ra = 4'(i);
            step();
            chk("clr_qv_a", {23'd0, qv_a}, 24'd1);
            chk("clr_q_a", q_a, 24'h000000);
            chk("clr_q_b", q_b, 24'h000000);
            chk("clr_qv_c", {23'd0, qv_c}, (i > 0) ? 24'd1 : 24'd0);
            chk("clr_q_c", q_c, 24'h000000);
        end
        re = 1'b0;
        step();
        chk("clr_end_qv_a", {23'd0, qv_a}, 24'd0);
        chk("clr_end_qv_c", {23'd0, qv_c}, 24'd1);
        step();
        chk("clr_end2_qv_c", {23'd0, qv_c}, 24'd0);

        // Mid-clear reset restarts the sweep; requests during BUSY are ignored
        wr(4'd3, 24'h777777, 3'b111);
        do_reset();
        repeat (7) step();
        do_reset();
        we = 1'b1; wa = 4'd3; d = 24'hFFFFFF; wbe = 3'b111;
        re = 1'b1; ra = 4'd3;
        n = 0;
        while (busy_a === 1'b1 && n < 100) begin
            n++;
            step();
            chk("busy_qv_a", {23'd0, qv_a}, 24'd0);
        end
        we = 1'b0; re = 1'b0;
        chk("busy_len_mid", 24'(n), 24'd16);
        rd("midclr_addr3", 4'd3, 24'h000000, 24'h000000, 24'h000000);

        // Byte enables
        wr(4'hA, 24'h112233, 3'b111);
        wr(4'hA, 24'hAABBCC, 3'b010);
        rd("be_merge", 4'hA, 24'h11BB33, 24'h11BB33, 24'h11BB33);
        wr(4'hA, 24'hFFFFFF, 3'b000);
        rd("be_none", 4'hA, 24'h11BB33, 24'h11BB33, 24'h11BB33);

        // Same-address collision
        wr(4'd5, 24'h123456, 3'b111);
        we = 1'b1; wa = 4'd5; d = 24'hDEADBE; wbe = 3'b001;
        re = 1'b1; ra = 4'd5;
        step();
        we = 1'b0; re = 1'b0;
        chk("coll_old_a", q_a, 24'h123456);
        chk("coll_new_b", q_b, 24'h1234BE);
        step();
        chk("coll_old_c", q_c, 24'h123456);
        rd("coll_after", 4'd5, 24'h1234BE, 24'h1234BE, 24'h1234BE);

        // Back-to-back reads; addr 0 is overwritten while its data is in flight
        wr(4'd0, 24'd10, 3'b111);
        wr(4'd1, 24'd20, 3'b111);
        wr(4'd2, 24'd30, 3'b111);
        wr(4'd3, 24'd40, 3'b111);
        re = 1'b1;
        ra = 4'd0;
        for (int k = 0; k < 6; k++) begin
            step();
            ra = 4'(k + 1);
            re = (k < 3);
            we = (k == 0);
            wa = 4'd0; d = 24'hFFFFFF; wbe = 3'b111;
            chk("pipe_qv_c", {23'd0, qv_c}, (k >= 1 && k <= 4) ? 24'd1 : 24'd0);
            if (k >= 1 && k <= 4) chk("pipe_q_c", q_c, 24'(10 * k));
            chk("pipe_qv_a", {23'd0, qv_a}, (k <= 3) ? 24'd1 : 24'd0);
            if (k <= 3) chk("pipe_q_a", q_a, 24'(10 * (k + 1)));
        end
        we = 1'b0;

        // Output enable releases the bus without affecting QV or the held word
        oe = 1'b0;
        re = 1'b1;
        ra = 4'd2;
        step();
        re = 1'b0;
        chk("oe_qv_a", {23'd0, qv_a}, 24'd1);
        ntests++;
        assert (q_a !== 24'd30) else begin
            nfail++;
            $error("FAIL oe_off_q_a: observed %h expected released bus", q_a);
        end
        step();
        chk("oe_qv_c", {23'd0, qv_c}, 24'd1);
        ntests++;
        assert (q_c !== 24'd30) else begin
            nfail++;
            $error("FAIL oe_off_q_c: observed %h expected released bus", q_c);
        end
        oe = 1'b1;
        #1;
        chk("oe_on_q_a", q_a, 24'd30);
        chk("oe_on_q_b", q_b, 24'd30);
        chk("oe_on_q_c", q_c, 24'd30);
        do_reset();
        chk("rst2_q_a", q_a, 24'h000000);
        chk("rst2_q_c", q_c, 24'h000000);
        chk("rst2_qv_c", {23'd0, qv_c}, 24'd0);
        count_busy(n);
        chk("busy_len_last", 24'(n), 24'd16);

        $display("[TB] %0d tests run, %0d failed", ntests, nfail);
        $finish;
    end

endmodule
